// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver delivering bytes over valid/ready with frame-error and overrun pulses
module uart_cmd_rx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    sync_q;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, overrun_q, overrun_d, rx_busy_q;
  logic          deliver, ferr, load, rxd_s;

  assign rxd_s     = sync_q[1];
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_busy   = rx_busy_q;

  // Next-state: sample mid-bit, shift LSB first, then hand the byte to the holding register
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    deliver   = 1'b0;
    ferr      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = rxd_s ? IDLE : START;
      end
      START: if (cnt_q == HALF_LAST) begin
        cnt_d     = '0;
        bit_idx_d = '0;
        state_d   = rxd_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == BIT_LAST) begin
        cnt_d     = '0;
        shift_d   = {rxd_s, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        state_d   = (bit_idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt_q == BIT_LAST) begin
        cnt_d   = '0;
        deliver = rxd_s;
        ferr    = ~rxd_s;
        state_d = rxd_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        cnt_d   = '0;
        state_d = rxd_s ? IDLE : WAIT_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    load       = deliver & (~rx_valid_q | rx_ready);
    rx_valid_d = load | (rx_valid_q & ~rx_ready);
    rx_data_d  = load ? shift_q : rx_data_q;
    overrun_d  = deliver & rx_valid_q & ~rx_ready;
  end

  // State, counters, synchronizer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      sync_q      <= 2'b11;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      sync_q      <= {sync_q[0], uart_rxd};
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= ferr;
      overrun_q   <= overrun_d;
      rx_busy_q   <= (state_q != IDLE);
    end
  end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: scoreboard bench for uart_cmd_rx at 10 clocks per bit
module tb_uart_cmd_rx;
  localparam int C = 10;

  logic       clk = 1'b0;
  logic       rst, uart_rxd, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, rx_busy;

  int checks = 0, errors = 0, cyc = 0, fe_cnt = 0, ov_cnt = 0, lat1 = 98;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  uart_cmd_rx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .overrun(overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rxd = 1'b0;
    step(C);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      step(C);
    end
    uart_rxd = 1'b1;
    step(C);
  endtask

  task automatic test_reset;
    rst = 1'b1; uart_rxd = 1'b1; rx_ready = 1'b0;
    step(3);
    checks++;
    if ({rx_valid, frame_err, overrun, rx_busy} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b required 0000", {rx_valid, frame_err, overrun, rx_busy});
    end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %02h required 00", rx_data); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_single;
    int s, fe0, ov0;
    logic v;
    logic [7:0] g, e;
    fe0 = fe_cnt; ov0 = ov_cnt; rx_ready = 1'b1; v = 1'b0;
    s = cyc;
    exp_q.push_back(8'h55);
    fork send_byte(8'h55); join_none
    for (int i = 0; i < 150 && !v; i++) begin @(negedge clk); v = rx_valid; end
    checks++;
    if (!v || cyc - s - 1 < 97 || cyc - s - 1 > 99) begin
      errors++; $display("FAIL latency got %0d valid %b required 98+-1", cyc - s - 1, v);
    end else lat1 = cyc - s - 1;
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got %b required 0", rx_valid); end
    wait fork;
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL single_count got %0d required 1", got_q.size()); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL single_data got %02h required %02h", g, e); end
    end
    checks++;
    if (fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++; $display("FAIL single_flags got fe %0d ov %0d required 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_overrun;
    int ov0;
    logic [7:0] g, e;
    rx_ready = 1'b0; ov0 = ov_cnt;
    exp_q.push_back(8'hA3);
    send_byte(8'hA3);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA3 || ov_cnt != ov0) begin
      errors++; $display("FAIL ovr_first got v %b d %02h ov %0d required 1 a3 0", rx_valid, rx_data, ov_cnt - ov0);
    end
    send_byte(8'h0F);
    checks++;
    if (ov_cnt != ov0 + 1) begin errors++; $display("FAIL ovr_pulse got %0d required 1", ov_cnt - ov0); end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA3) begin
      errors++; $display("FAIL ovr_hold got v %b d %02h required 1 a3", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    step(1);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drop_valid got %b required 0", rx_valid); end
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL ovr_count got %0d required 1", got_q.size()); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL ovr_data got %02h required %02h", g, e); end
    end
  endtask

  task automatic test_glitch;
    int fe0, ov0, last;
    fe0 = fe_cnt; ov0 = ov_cnt; last = -1; rx_ready = 1'b1;
    uart_rxd = 1'b0;
    step(3);
    uart_rxd = 1'b1;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (rx_busy) last = i; end
    checks++;
    if (last < 0 || last >= 8) begin errors++; $display("FAIL glitch_busy got last %0d required 0..7", last); end
    checks++;
    if (got_q.size() != 0 || fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++; $display("FAIL glitch_quiet got bytes %0d fe %0d ov %0d required 0 0 0", got_q.size(), fe_cnt - fe0, ov_cnt - ov0);
    end
    step(1);
  endtask

  task automatic test_break;
    int fe0;
    logic [7:0] g, e;
    fe0 = fe_cnt; rx_ready = 1'b1;
    uart_rxd = 1'b0;
    step(30 * C);
    checks++;
    if (fe_cnt != fe0 + 1) begin errors++; $display("FAIL break_ferr got %0d required 1", fe_cnt - fe0); end
    checks++;
    if (got_q.size() != 0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL break_novalid got bytes %0d v %b required 0 0", got_q.size(), rx_valid);
    end
    uart_rxd = 1'b1;
    step(2 * C);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E);
    step(2);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL break_count got %0d required 1", got_q.size()); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL break_data got %02h required %02h", g, e); end
    end
    checks++;
    if (fe_cnt != fe0 + 1) begin errors++; $display("FAIL break_ferr_after got %0d required 1", fe_cnt - fe0); end
  endtask

  task automatic test_back_to_back;
    int fe0, ov0;
    logic [7:0] g, e;
    logic [7:0] seq [3];
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h96;
    fe0 = fe_cnt; ov0 = ov_cnt; rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin exp_q.push_back(seq[i]); send_byte(seq[i]); end
    step(2);
    checks++;
    if (got_q.size() != 3) begin errors++; $display("FAIL b2b_count got %0d required 3", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_data got %02h required %02h", g, e); end
    end
    checks++;
    if (fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++; $display("FAIL b2b_flags got fe %0d ov %0d required 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_collide;
    int s, ov0;
    logic [7:0] g, e;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_byte(8'h11);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      errors++; $display("FAIL coll_hold got v %b d %02h required 1 11", rx_valid, rx_data);
    end
    ov0 = ov_cnt;
    exp_q.push_back(8'hC4);
    s = cyc;
    fork send_byte(8'hC4); join_none
    while (cyc < s + lat1) step(1);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hC4) begin
      errors++; $display("FAIL coll_load got v %b d %02h required 1 c4", rx_valid, rx_data);
    end
    checks++;
    if (ov_cnt != ov0) begin errors++; $display("FAIL coll_overrun got %0d required 0", ov_cnt - ov0); end
    wait fork;
    rx_ready = 1'b1;
    step(2);
    checks++;
    if (got_q.size() != 2) begin errors++; $display("FAIL coll_count got %0d required 2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL coll_data got %02h required %02h", g, e); end
    end
  endtask

  task automatic test_reset_mid;
    int fe0;
    logic [7:0] g, e;
    rx_ready = 1'b0;
    send_byte(8'h5A);
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b required 1", rx_valid); end
    fe0 = fe_cnt;
    fork send_byte(8'hF5); join_none
    step(5 * C + 5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if ({rx_valid, frame_err, overrun, rx_busy} !== 4'b0 || rx_data !== 8'h00) begin
      errors++; $display("FAIL rmid_reset got v%b fe%b ov%b busy%b d %02h required all 0",
                         rx_valid, frame_err, overrun, rx_busy, rx_data);
    end
    wait fork;
    step(C);
    checks++;
    if (rx_valid !== 1'b0 || fe_cnt != fe0) begin
      errors++; $display("FAIL rmid_nobyte got v %b fe %0d required 0 0", rx_valid, fe_cnt - fe0);
    end
    rx_ready = 1'b1;
    exp_q.push_back(8'h3C);
    send_byte(8'h3C);
    step(2);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL rmid_count got %0d required 1", got_q.size()); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL rmid_data got %02h required %02h", g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_glitch();
    test_break();
    test_back_to_back();
    test_collide();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d required 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish required finish");
    $fatal(1);
  end
endmodule
